// File: rtl/fifo_rr_scheduler_if.sv
// Bundle of source-FIFO, destination-FIFO and status signals around the
// round-robin scheduler. The slave view belongs to the scheduler; the master
// view belongs to whatever surrounds it (the FIFOs or a testbench).
interface fifo_rr_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 8
);
    logic                    enable;
    logic [3:0]              in_empty;
    logic [4*DATA_WIDTH-1:0] in_data;
    logic [3:0]              in_rd_en;
    logic                    out_almost_full;
    logic                    out_full;
    logic                    out_wr_en;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [1:0]              grant_id;
    logic                    busy;
    logic [CNT_WIDTH-1:0]    xfer_count;

    modport master (
        output enable, in_empty, in_data, out_almost_full, out_full,
        input  in_rd_en, out_wr_en, out_data, grant_id, busy, xfer_count
    );

    modport slave (
        input  enable, in_empty, in_data, out_almost_full, out_full,
        output in_rd_en, out_wr_en, out_data, grant_id, busy, xfer_count
    );
endinterface

// File: rtl/fifo_rr_scheduler.sv
// Round-robin mover from four source FIFOs into one destination FIFO.
// Each word takes a POP cycle (rd_en to the winning source) followed by a
// PUSH cycle (wr_en to the destination); PUSH can chain straight into the
// next POP, giving one word every two cycles.
module fifo_rr_scheduler #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                rst,
    fifo_rr_scheduler_if.slave  bus
);
    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_SRC-1:0]   r_rd_en;
    logic [NUM_SRC-1:0]   w_rd_en_nxt;
    logic                 r_wr_en;
    logic                 w_wr_en_nxt;
    logic [SEL_W-1:0]     r_grant_id;
    logic [SEL_W-1:0]     w_grant_id_nxt;
    logic [SEL_W-1:0]     r_last_grant;
    logic [SEL_W-1:0]     w_last_grant_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic [CNT_WIDTH-1:0] r_xfer_count;
    logic [CNT_WIDTH-1:0] w_xfer_count_nxt;

    logic                 w_any_src;
    logic [SEL_W-1:0]     w_winner;
    logic                 w_grant_ok;
    logic [DATA_WIDTH-1:0] w_out_data;

    // Search upward from the source after the last grant, wrapping 3 -> 0.
    always_comb begin : winner_search
        logic [SEL_W-1:0] v_idx;
        w_any_src = 1'b0;
        w_winner  = r_last_grant;
        v_idx     = '0;
        for (int k = 1; k <= int'(NUM_SRC); k++) begin
            v_idx = SEL_W'(32'(r_last_grant) + 32'(k));
            if (!w_any_src && !bus.in_empty[v_idx]) begin
                w_any_src = 1'b1;
                w_winner  = v_idx;
            end
        end
    end

    // A new word may start only when the destination has room to spare.
    assign w_grant_ok = bus.enable && !bus.out_almost_full && !bus.out_full && w_any_src;

    // Next-state and next-output logic; a POP always runs into its PUSH.
    always_comb begin
        w_state_nxt      = r_state;
        w_rd_en_nxt      = '0;
        w_wr_en_nxt      = 1'b0;
        w_grant_id_nxt   = r_grant_id;
        w_last_grant_nxt = r_last_grant;
        w_xfer_count_nxt = r_xfer_count;
        case (r_state)
            IDLE: begin
                if (w_grant_ok) begin
                    w_state_nxt      = POP;
                    w_rd_en_nxt      = NUM_SRC'(4'b0001 << w_winner);
                    w_grant_id_nxt   = w_winner;
                    w_last_grant_nxt = w_winner;
                end
            end
            POP: begin
                w_state_nxt = PUSH;
                w_wr_en_nxt = 1'b1;
            end
            PUSH: begin
                w_xfer_count_nxt = r_xfer_count + CNT_WIDTH'(1);
                if (w_grant_ok) begin
                    w_state_nxt      = POP;
                    w_rd_en_nxt      = NUM_SRC'(4'b0001 << w_winner);
                    w_grant_id_nxt   = w_winner;
                    w_last_grant_nxt = w_winner;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // State and registered outputs; reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_rd_en      <= '0;
            r_wr_en      <= 1'b0;
            r_grant_id   <= '0;
            r_last_grant <= SEL_W'(NUM_SRC - 1);
            r_busy       <= 1'b0;
            r_xfer_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_busy       <= w_busy_nxt;
            r_xfer_count <= w_xfer_count_nxt;
        end
    end

    // Destination data follows the granted source's FIFO output.
    always_comb begin
        w_out_data = bus.in_data[0 +: DATA_WIDTH];
        case (r_grant_id)
            2'd0: w_out_data = bus.in_data[0*DATA_WIDTH +: DATA_WIDTH];
            2'd1: w_out_data = bus.in_data[1*DATA_WIDTH +: DATA_WIDTH];
            2'd2: w_out_data = bus.in_data[2*DATA_WIDTH +: DATA_WIDTH];
            default: w_out_data = bus.in_data[3*DATA_WIDTH +: DATA_WIDTH];
        endcase
    end

    assign bus.in_rd_en   = r_rd_en;
    assign bus.out_wr_en  = r_wr_en;
    assign bus.out_data   = w_out_data;
    assign bus.grant_id   = r_grant_id;
    assign bus.busy       = r_busy;
    assign bus.xfer_count = r_xfer_count;
endmodule

// File: doc/fifo_rr_scheduler.md
FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, meaning width of every data word.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, meaning width of xfer_count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (0 sampled at posedge clk resets the block).
REQ-005 enable  input  1  1 = new grants allowed.
REQ-006 in_empty  input  4  buf_empty of source FIFOs 0..3.
REQ-007 in_data  input  4*DATA_WIDTH  buf_out of source FIFOs; source i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 in_rd_en  output  4  one-hot rd_en to source FIFOs.
REQ-009 out_almost_full  input  1  almost_full of destination FIFO.
REQ-010 out_full  input  1  buf_full of destination FIFO.
REQ-011 out_wr_en  output  1  wr_en to destination FIFO.
REQ-012 out_data  output  DATA_WIDTH  buf_in to destination FIFO.
REQ-013 grant_id  output  2  index of the source currently or last granted.
REQ-014 busy  output  1  1 while state is not IDLE.
REQ-015 xfer_count  output  CNT_WIDTH  number of words written to destination.

Function
REQ-016 SHALL implement FSM with states IDLE, POP, PUSH; in_rd_en, out_wr_en, grant_id, busy and xfer_count are registered.
REQ-017 Grant condition: enable=1, out_almost_full=0, out_full=0, and at least one in_empty bit = 0.
REQ-018 Winner: first source with in_empty=0, searching upward from (last_grant+1) mod 4, wrapping 3->0.
REQ-019 IDLE: if grant condition holds, go to POP; set in_rd_en to one-hot of winner, grant_id and last_grant to winner; else stay IDLE with in_rd_en=0.
REQ-020 POP: lasts exactly one cycle with in_rd_en[grant_id]=1; next state PUSH, in_rd_en cleared.
REQ-021 PUSH: out_wr_en=1 for exactly this cycle; out_data = in_data slice grant_id (combinational mux on registered grant_id); xfer_count increments by 1 at end of cycle, wrapping modulo 2^CNT_WIDTH.
REQ-022 PUSH exit: if grant condition holds, go directly to POP with a new winner (2-cycle throughput); else go to IDLE.
REQ-023 out_data SHALL equal in_data slice grant_id in all states; it is only meaningful while out_wr_en=1.
REQ-024 A word in POP SHALL always complete its PUSH, even if enable, out_almost_full or out_full change.
REQ-025 Destination almost_full threshold SHALL leave at least one free entry; this guarantee is what makes REQ-024 safe.
REQ-026 Only one in_rd_en bit SHALL ever be 1, and in_rd_en and out_wr_en SHALL never both be 1 in the same cycle.
REQ-027 A source with in_empty=1 SHALL never be granted; a source that empties mid-round is skipped.
REQ-028 enable=0 SHALL block new grants only; the in-flight word completes and the FSM then idles.

Reset
REQ-029 rst=0 at posedge SHALL force IDLE, in_rd_en=0, out_wr_en=0, grant_id=0, busy=0, xfer_count=0, last_grant=3 (first search starts at source 0).
REQ-030 rst mid-operation (POP or PUSH) SHALL abort; a word already popped from a source is discarded and out_wr_en is not asserted for it.
REQ-031 rst has priority over every other input.

Verification
REQ-032 Reset, sources 0..3 each loaded with 1 word (values 1,2,3,4), enable=1 -> writes in order 1,2,3,4; grant_id 0,1,2,3; xfer_count=4; out_wr_en spaced every 2 cycles.
REQ-033 Only source 2 non-empty with 3 words (5,6,7) -> three consecutive POP/PUSH pairs from source 2 with no IDLE gap; outputs 5,6,7.
REQ-034 out_almost_full raised during POP -> that word still written once; no further in_rd_en until out_almost_full=0.
REQ-035 enable=0 while sources non-empty -> in_rd_en stays 0, busy=0; enable=1 -> grants resume at (last_grant+1).
REQ-036 rst=0 during PUSH -> next cycle out_wr_en=0, in_rd_en=0, xfer_count=0, grant_id=0; first grant after release goes to the lowest non-empty source.
REQ-037 xfer_count at 255 plus one transfer -> reads 0.
